// File: rtl/nested_loop_agu_pkg.sv
// Shared types and width helpers for the nested-loop address generator.
// Optional feature macro (used by the top): NESTED_LOOP_AGU_ABORT_EN.
package nested_loop_agu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_LEVELS = 3;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_CNT_W  = 8;

    // An offset holds idx*stride, so it needs ADDR_W+CNT_W bits; the sum adds two guard bits.
    localparam int DEF_OFF_W = DEF_ADDR_W + DEF_CNT_W;
    localparam int DEF_SUM_W = DEF_ADDR_W + DEF_CNT_W + 2;

    typedef logic [DEF_LEVELS-1:0][DEF_CNT_W-1:0]  bound_arr_t;
    typedef logic [DEF_LEVELS-1:0][DEF_ADDR_W-1:0] stride_arr_t;

    function automatic int off_width(input int addr_w, input int cnt_w);
        return addr_w + cnt_w;
    endfunction

    function automatic int sum_width(input int addr_w, input int cnt_w);
        return addr_w + cnt_w + 2;
    endfunction

endpackage

// File: rtl/nested_loop_agu_level.sv
// One loop level: trip counter plus incrementally accumulated offset (idx*stride).
module loop_level_cnt
    import nested_loop_agu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             inc_en,
    input  logic [CNT_W-1:0]                 bound,
    input  logic [ADDR_W-1:0]                stride,
    output logic [CNT_W-1:0]                 idx,
    output logic [off_width(ADDR_W, CNT_W)-1:0] off,
    output logic                             at_last,
    output logic                             carry
);

    localparam int OFF_W = off_width(ADDR_W, CNT_W);

    logic [CNT_W-1:0] idx_q, idx_d;
    logic [OFF_W-1:0] off_q, off_d;

    assign at_last = (idx_q == (bound - CNT_W'(1)));
    assign carry   = inc_en & at_last;
    assign idx     = idx_q;
    assign off     = off_q;

    // Wrapping resets the offset to zero, so no multiply is ever needed.
    always_comb begin
        idx_d = idx_q;
        off_d = off_q;
        if (clr) begin
            idx_d = '0;
            off_d = '0;
        end else if (inc_en) begin
            if (at_last) begin
                idx_d = '0;
                off_d = '0;
            end else begin
                idx_d = idx_q + CNT_W'(1);
                off_d = off_q + OFF_W'(stride);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            off_q <= '0;
        end else begin
            idx_q <= idx_d;
            off_q <= off_d;
        end
    end

endmodule

// File: rtl/nested_loop_agu.sv
// Nested-loop address generator: addr = base + sum(idx[k]*stride[k]) as a valid/ready stream.
// Define NESTED_LOOP_AGU_ABORT_EN to add the abort input.
module nested_loop_agu
    import nested_loop_agu_pkg::*;
#(
    parameter int LEVELS = 3,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
`ifdef NESTED_LOOP_AGU_ABORT_EN
    input  logic                           abort,
`endif
    input  logic [ADDR_W-1:0]              base,
    input  logic [LEVELS-1:0][CNT_W-1:0]   bound,
    input  logic [LEVELS-1:0][ADDR_W-1:0]  stride,
    output logic                           idle,
    output logic                           addr_valid,
    input  logic                           addr_ready,
    output logic [ADDR_W-1:0]              addr,
    output logic                           addr_last,
    output logic                           done,
    output logic                           overflow
);

    localparam int OFF_W = off_width(ADDR_W, CNT_W);
    localparam int SUM_W = sum_width(ADDR_W, CNT_W);

    state_t                         state_q;
    logic [ADDR_W-1:0]              base_q;
    logic [LEVELS-1:0][CNT_W-1:0]   bound_q;
    logic [LEVELS-1:0][ADDR_W-1:0]  stride_q;
    logic                           overflow_q;
    logic                           done_q;

    logic [LEVELS-1:0][CNT_W-1:0]   idx;
    logic [LEVELS-1:0][OFF_W-1:0]   off;
    logic [LEVELS-1:0]              atLast;
    logic [LEVELS-1:0]              carry;
    logic [LEVELS-1:0]              incEn;
    logic [SUM_W-1:0]               sum;
    logic                           startAcc;
    logic                           advance;
    logic                           anyZero;
    logic                           abortReq;

`ifdef NESTED_LOOP_AGU_ABORT_EN
    assign abortReq = abort;
`else
    assign abortReq = 1'b0;
`endif

    assign startAcc = (state_q == IDLE) & start;
    assign advance  = (state_q == RUN) & addr_ready & ~abortReq;
    assign incEn[0] = advance;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        loop_level_cnt #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_level (
            .clk     (clk),
            .rst     (rst),
            .clr     (startAcc),
            .inc_en  (incEn[k]),
            .bound   (bound_q[k]),
            .stride  (stride_q[k]),
            .idx     (idx[k]),
            .off     (off[k]),
            .at_last (atLast[k]),
            .carry   (carry[k])
        );
        if (k > 0) begin : g_chain
            assign incEn[k] = carry[k-1];
        end
        a_idx_in_range: assert property (@(posedge clk) disable iff (rst)
            (state_q == RUN) |-> (idx[k] < bound_q[k]));
    end

    always_comb begin
        anyZero = 1'b0;
        for (int k = 0; k < LEVELS; k++) begin
            if (bound[k] == '0) anyZero = 1'b1;
        end
    end

    always_comb begin
        sum = SUM_W'(base_q);
        for (int k = 0; k < LEVELS; k++) begin
            sum = sum + SUM_W'(off[k]);
        end
    end

    // The outermost carry fires exactly on the handshake of the final address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            bound_q    <= '0;
            stride_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q     <= base;
                        bound_q    <= bound;
                        stride_q   <= stride;
                        overflow_q <= 1'b0;
                        if (anyZero) done_q  <= 1'b1;
                        else         state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abortReq) begin
                        state_q <= IDLE;
                    end else if (advance) begin
                        if (sum[SUM_W-1:ADDR_W] != '0) overflow_q <= 1'b1;
                        if (carry[LEVELS-1]) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idle       = (state_q == IDLE);
    assign addr_valid = (state_q == RUN);
    assign addr       = sum[ADDR_W-1:0];
    assign addr_last  = (state_q == RUN) & (&atLast);
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_nested_loop_agu.sv
// Self-checking bench for nested_loop_agu: table vectors, corner sequences and random runs vs. a model.
module tb_nested_loop_agu;

    localparam int LEVELS = 3;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 8;
    localparam int BUDGET = 2000;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          start;
    logic                          abort;
    logic [ADDR_W-1:0]             base;
    logic [LEVELS-1:0][CNT_W-1:0]  bound;
    logic [LEVELS-1:0][ADDR_W-1:0] stride;
    logic                          addrReady;
    logic                          idle;
    logic                          addrValid;
    logic [ADDR_W-1:0]             addr;
    logic                          addrLast;
    logic                          done;
    logic                          overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string                         name;
        int                            baseV;
        logic [LEVELS-1:0][CNT_W-1:0]  bnd;
        logic [LEVELS-1:0][ADDR_W-1:0] str;
        int                            readyMode;
        int                            expCount;
        int                            expLast;
        bit                            expOvf;
    } vec_t;

    typedef struct {
        int addrV;
        bit ovf;
    } beat_t;

    beat_t expQ[$];

    nested_loop_agu #(
        .LEVELS (LEVELS),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef NESTED_LOOP_AGU_ABORT_EN
        .abort      (abort),
`endif
        .base       (base),
        .bound      (bound),
        .stride     (stride),
        .idle       (idle),
        .addr_valid (addrValid),
        .addr_ready (addrReady),
        .addr       (addr),
        .addr_last  (addrLast),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: enumerate the iteration space in mixed radix, level 0 fastest.
    function automatic void buildModel(input int baseV,
                                       input logic [LEVELS-1:0][CNT_W-1:0] bnd,
                                       input logic [LEVELS-1:0][ADDR_W-1:0] str);
        longint count = 1;
        expQ.delete();
        for (int k = 0; k < LEVELS; k++) count = count * longint'(bnd[k]);
        for (longint n = 0; n < count; n++) begin
            longint rem  = n;
            longint full = longint'(baseV);
            beat_t  b;
            for (int k = 0; k < LEVELS; k++) begin
                full = full + (rem % longint'(bnd[k])) * longint'(str[k]);
                rem  = rem / longint'(bnd[k]);
            end
            b.addrV = int'(full % 256);
            b.ovf   = (full > 255);
            expQ.push_back(b);
        end
    endfunction

    function automatic bit readyFor(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic applyStimulus(input vec_t v);
        int cyc      = 0;
        int dutCount = 0;
        int dutLast  = -1;
        bit expOvf   = 1'b0;
        buildModel(v.baseV, v.bnd, v.str);
        base   = ADDR_W'(v.baseV);
        bound  = v.bnd;
        stride = v.str;
        start  = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({v.name, ".ovfClearedAtStart"}, overflow, 0);
        while (expQ.size() > 0 && cyc < BUDGET) begin
            addrReady = readyFor(v.readyMode, cyc);
            checkOutput({v.name, ".valid"}, addrValid, 1);
            checkOutput({v.name, ".addr"}, addr, expQ[0].addrV);
            checkOutput({v.name, ".last"}, addrLast, (expQ.size() == 1));
            checkOutput({v.name, ".ovfSticky"}, overflow, expOvf);
            if (addrValid && addrReady) begin
                dutCount++;
                dutLast = int'(addr);
            end
            tick();
            if (addrReady) begin
                expOvf = expOvf | expQ[0].ovf;
                void'(expQ.pop_front());
            end
            cyc++;
        end
        addrReady = 1'b0;
        if (cyc >= BUDGET) checkOutput({v.name, ".timeout"}, 1, 0);
        checkOutput({v.name, ".donePulse"}, done, 1);
        checkOutput({v.name, ".validAfter"}, addrValid, 0);
        checkOutput({v.name, ".idleAfter"}, idle, 1);
        checkOutput({v.name, ".count"}, dutCount, v.expCount);
        checkOutput({v.name, ".lastAddr"}, dutLast, v.expLast);
        checkOutput({v.name, ".ovfFinal"}, overflow, v.expOvf);
        tick();
        checkOutput({v.name, ".doneOneCycle"}, done, 0);
    endtask

    vec_t vecs[5];

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        addrReady = 1'b0;
        base      = '0;
        bound     = '0;
        stride    = '0;
        tick();
        tick();
        checkOutput("rst.idle", idle, 1);
        checkOutput("rst.valid", addrValid, 0);
        checkOutput("rst.addr", addr, 0);
        checkOutput("rst.last", addrLast, 0);
        checkOutput("rst.done", done, 0);
        checkOutput("rst.ovf", overflow, 0);
        rst = 1'b0;
        tick();

        vecs[0] = '{"sweep2d",   1,   {8'd1, 8'd6, 8'd4}, {8'd0,  8'd3, 8'd2}, 0, 24, 22,  1'b0};
        vecs[1] = '{"backpress", 1,   {8'd1, 8'd6, 8'd4}, {8'd0,  8'd3, 8'd2}, 1, 24, 22,  1'b0};
        vecs[2] = '{"ovf",       250, {8'd1, 8'd1, 8'd3}, {8'd0,  8'd0, 8'd4}, 0, 3,  2,   1'b1};
        vecs[3] = '{"cube3d",    10,  {8'd2, 8'd3, 8'd2}, {8'd16, 8'd4, 8'd1}, 2, 12, 35,  1'b0};
        vecs[4] = '{"single",    77,  {8'd1, 8'd1, 8'd1}, {8'd5,  8'd9, 8'd7}, 0, 1,  77,  1'b0};
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        // Zero-trip run: no beats, done one cycle after start, never leaves IDLE.
        base   = 8'd40;
        bound  = {8'd1, 8'd0, 8'd4};
        stride = {8'd0, 8'd3, 8'd2};
        start  = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("zero.done", done, 1);
        checkOutput("zero.idle", idle, 1);
        checkOutput("zero.valid", addrValid, 0);
        tick();
        checkOutput("zero.doneOneCycle", done, 0);
        checkOutput("zero.validStill", addrValid, 0);

        // Reset mid-run after five handshakes, with overflow already set.
        base      = 8'd250;
        bound     = {8'd1, 8'd3, 8'd4};
        stride    = {8'd0, 8'd1, 8'd4};
        start     = 1'b1;
        tick();
        start     = 1'b0;
        addrReady = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        addrReady = 1'b0;
        checkOutput("midrst.ovfBefore", overflow, 1);
        checkOutput("midrst.addrBefore", addr, 255);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst.idle", idle, 1);
        checkOutput("midrst.valid", addrValid, 0);
        checkOutput("midrst.ovf", overflow, 0);
        checkOutput("midrst.done", done, 0);
        tick();
        checkOutput("midrst.noDone", done, 0);
        applyStimulus(vecs[0]);

`ifdef NESTED_LOOP_AGU_ABORT_EN
        // Abort on the third address; a start mid-run is ignored.
        base   = 8'd1;
        bound  = {8'd1, 8'd6, 8'd4};
        stride = {8'd0, 8'd3, 8'd2};
        start  = 1'b1;
        tick();
        start     = 1'b0;
        addrReady = 1'b1;
        checkOutput("abort.addr0", addr, 1);
        base  = 8'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("abort.startIgnored", addr, 3);
        checkOutput("abort.stillRun", idle, 0);
        tick();
        checkOutput("abort.addr2", addr, 5);
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        addrReady = 1'b0;
        checkOutput("abort.idle", idle, 1);
        checkOutput("abort.valid", addrValid, 0);
        checkOutput("abort.noDone", done, 0);
        tick();
        checkOutput("abort.noDoneLater", done, 0);
`endif

        // Random configurations with random backpressure against the model.
        for (int r = 0; r < 8; r++) begin
            vec_t v;
            longint full;
            v.name      = "rand";
            v.baseV     = int'($urandom_range(0, 255));
            v.readyMode = 2;
            v.expCount  = 1;
            full        = longint'(v.baseV);
            for (int k = 0; k < LEVELS; k++) begin
                v.bnd[k]   = CNT_W'($urandom_range(1, 4));
                v.str[k]   = ADDR_W'($urandom_range(0, 255));
                v.expCount = v.expCount * int'(v.bnd[k]);
                full       = full + longint'(v.bnd[k] - 1) * longint'(v.str[k]);
            end
            v.expLast = int'(full % 256);
            buildModel(v.baseV, v.bnd, v.str);
            v.expOvf = 1'b0;
            foreach (expQ[j]) v.expOvf = v.expOvf | expQ[j].ovf;
            applyStimulus(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nested_loop_agu.md
Name: nested_loop_agu

Overview:
- Parametrised successor to the fixed two-loop address FSM/datapath pair.
- Generates the address stream of an up-to-LEVELS-deep nested loop: addr = base + sum(idx[k]*stride[k]).
- Bounds, strides and base are runtime configuration, latched at start.
- Output is a valid/ready stream with last-flag, done pulse and sticky overflow; sits between the controller and a memory port.

Parameters:
- LEVELS, 3, number of loop levels (1..4); level 0 is innermost.
- ADDR_W, 32, output address width.
- CNT_W, 8, loop-counter/bound width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only while idle=1.
- base  in  ADDR_W  base address, latched at start.
- bound  in  LEVELS x CNT_W  trip count per level, latched at start.
- stride  in  LEVELS x ADDR_W  unsigned stride per level, latched at start.
- idle  out  1  1 when in IDLE.
- addr_valid  out  1  addr holds a valid address.
- addr_ready  in  1  consumer accepts addr this cycle.
- addr  out  ADDR_W  current address (low ADDR_W bits of the true sum).
- addr_last  out  1  current address is the final one of the run.
- done  out  1  one-cycle pulse after the final handshake.
- overflow  out  1  sticky: some emitted address exceeded 2^ADDR_W-1.

Behaviour:
- Reset: state=IDLE, idle=1, addr_valid=0, addr=0, addr_last=0, done=0, overflow=0; all counters and offsets are 0.
- Reset mid-run abandons the run; no done pulse is produced.
- FSM states: IDLE, RUN.
  - IDLE: start=1 latches the configuration, clears all idx, offsets and overflow.
  - IDLE -> RUN next cycle; if any bound[k]==0, the FSM stays in IDLE and done pulses the next cycle (zero-trip run, no addresses emitted).
  - RUN: addr_valid=1. The first address (= base) is visible the cycle after start.
  - Handshake (addr_valid & addr_ready): advance like an odometer. idx[0]++; at bound[0]-1 it wraps to 0 and carries into idx[1], and so on.
  - Handshake with addr_last=1: RUN -> IDLE, done=1 for one cycle, addr_valid=0.
  - start during RUN is ignored.
- Stall: with addr_ready=0, addr, addr_last and all counters hold.
- Offsets: off[k] is ADDR_W+CNT_W bits wide, updated incrementally.
  - On increment of idx[k], off[k] += stride[k]; on wrap, off[k] = 0.
  - No multipliers are used.
- Address sum: computed in ADDR_W+CNT_W+2 bits; addr = sum[ADDR_W-1:0].
- Overflow: set on the handshake of any address whose upper sum bits are nonzero; held until the next accepted start or reset. The address is still emitted (truncated).
- addr_last = 1 when every idx[k] == bound[k]-1.
- Throughput: one address per cycle while addr_ready=1.
- Bound of 1 at any level: that level never increments and is always at its last value.
- Levels with index >= LEVELS do not exist; there is no masking at runtime.

Optional Feature:
- Macro: NESTED_LOOP_AGU_ABORT_EN.
- With the macro defined:
  - Adds input port abort (1 bit).
  - abort=1 in RUN forces IDLE next cycle, addr_valid=0, no done pulse; overflow keeps its value.
  - abort has priority over a simultaneous handshake; abort in IDLE is ignored.
- Without the macro: the port is absent and a run ends only on its final handshake or on rst.

Decomposition:
- Package nested_loop_agu_pkg:
  - state enum (IDLE, RUN).
  - localparams for the sum width (ADDR_W+CNT_W+2) and the offset width.
  - typedefs for the bound/stride array types.
- One sub-module, loop_level_cnt:
  - One level's counter plus offset accumulator.
  - Inputs: inc_en, bound, stride.
  - Outputs: idx, off, at_last, carry.
  - Instantiated LEVELS times with a generate loop; carry chains to the next level.

Test Plan:
- 2D sweep, matching the legacy block: LEVELS=2, bound={4,6}, stride={2,3}, base=1, ready=1 → 24 addresses.
  - Sequence 1,3,5,7,4,6,... up to 1+2*3+3*5=22.
  - addr_last on the 24th address; done the cycle after; idle=1 after that.
- Backpressure: same configuration, ready toggled 1,0,0,1,... → addr holds during ready=0, identical sequence, no skipped or duplicated addresses.
- Zero-trip run: bound[1]=0, start → no addr_valid ever; done pulses 1 cycle after start; idle stays 1.
- Overflow: ADDR_W=8, base=250, stride[0]=4, bound[0]=3 → addresses 250,254,2.
  - overflow rises at the handshake of the address 2 and stays set.
  - It clears on the next start.
- Reset mid-run: rst asserted after 5 handshakes → next cycle idle=1, addr_valid=0, overflow=0, no done.
  - A new start restarts from base.
- Abort (macro defined): abort with ready=1 on the 3rd address → no done, idle=1 next cycle.
  - start during RUN before the abort is ignored.
